// File: rtl/gate_checker_pkg.sv
// Shared types and truth-table constants for the 2-input gate checker.
package gate_check_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Expected y per input vector, bit index = {a,b}
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  localparam logic [1:0] VEC_LAST = 2'd3;

endpackage

// File: rtl/gate_checker_if.sv
// Stimulus/response and result bundle between the checker and its environment.
interface gate_checker_if;

  logic       start;
  logic       y;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;

  // The checker side drives the gate inputs and the results
  modport master (
    input  start, y,
    output a, b, busy, done, pass, err_count, fail_mask
  );

  // The environment side requests runs, returns y and reads results
  modport slave (
    output start, y,
    input  a, b, busy, done, pass, err_count, fail_mask
  );

endinterface

// File: rtl/gate_checker_hold_timer.sv
// Counts the cycles a vector has been held and flags the final hold cycle.
// HOLD is expected to lie in 2..255 so the count fits in 8 bits.
module hold_timer #(
  parameter int unsigned HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic last_o
);

  localparam logic [7:0] LAST_CNT = 8'(HOLD - 1);

  logic [7:0] holdCnt_q;
  logic [7:0] holdCnt_d;

  assign last_o = (holdCnt_q == LAST_CNT);

  // Wrap to zero after the last hold cycle so the next vector starts fresh
  always_comb begin
    holdCnt_d = holdCnt_q;
    if (clear_i) begin
      holdCnt_d = 8'd0;
    end else if (enable_i) begin
      holdCnt_d = last_o ? 8'd0 : holdCnt_q + 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      holdCnt_q <= 8'd0;
    end else begin
      holdCnt_q <= holdCnt_d;
    end
  end

endmodule

// File: rtl/gate_checker.sv
// Walks {a,b} through 00..11, samples y on the last hold cycle of each vector
// and accumulates pass/fail, error count and a per-vector fail mask.
module gate_checker
  import gate_check_pkg::*;
#(
  parameter logic [3:0]  EXPECTED = TT_AND,
  parameter int unsigned HOLD     = 4
) (
  input  logic clk,
  input  logic rst,
  gate_checker_if.master gif
);

  state_e     state_q;
  state_e     state_d;
  logic [1:0] vec_q;
  logic [2:0] errCount_q;
  logic [3:0] failMask_q;
  logic       pass_q;
  logic       done_q;

  logic       holdLast;
  logic       runActive;
  logic       vecSample;
  logic       startAccept;
  logic       mismatch;

  assign runActive   = (state_q == RUN);
  assign vecSample   = runActive && holdLast;
  assign startAccept = (state_q == IDLE) && gif.start;
  // Case inequality so an X/Z on y is treated as a failure in simulation
  assign mismatch    = (gif.y !== EXPECTED[vec_q]);

  hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (!runActive),
    .enable_i (runActive),
    .last_o   (holdLast)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave IDLE on start, return after the last vector's sample
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gif.start) state_d = RUN;
      RUN:     if (vecSample && (vec_q == VEC_LAST)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: gate inputs follow the vector only while running, else 0
  always_comb begin
    gif.busy = runActive;
    gif.a    = runActive ? vec_q[1] : 1'b0;
    gif.b    = runActive ? vec_q[0] : 1'b0;
  end

  // Vector index and result accumulation; results persist until the next start
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q      <= 2'd0;
      errCount_q <= 3'd0;
      failMask_q <= 4'd0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (startAccept) begin
        vec_q      <= 2'd0;
        errCount_q <= 3'd0;
        failMask_q <= 4'd0;
        pass_q     <= 1'b0;
      end else if (vecSample) begin
        if (mismatch) begin
          failMask_q[vec_q] <= 1'b1;
          errCount_q        <= errCount_q + 3'd1;
        end
        if (vec_q == VEC_LAST) begin
          done_q <= 1'b1;
          pass_q <= (failMask_q == 4'd0) && !mismatch;
        end else begin
          vec_q <= vec_q + 2'd1;
        end
      end
    end
  end

  assign gif.done      = done_q;
  assign gif.pass      = pass_q;
  assign gif.err_count = errCount_q;
  assign gif.fail_mask = failMask_q;

endmodule

// File: tb/tb_gate_checker.sv
// Scoreboard bench for gate_checker; a behavioural gate model drives y.
module tb_gate_checker;
  import gate_check_pkg::*;

  localparam int HOLD = 4;

  // Gate models presented on y
  localparam int M_AND    = 0;
  localparam int M_STUCK0 = 1;
  localparam int M_NAND   = 2;
  localparam int M_SETTLE = 3;

  typedef struct packed {
    logic       pass;
    logic [2:0] err;
    logic [3:0] mask;
  } result_t;

  logic    clk = 1'b0;
  logic    rst;
  result_t sbQueue[$];
  int      passCount = 0;
  int      checkCount = 0;

  gate_checker_if gif();

  gate_checker #(
    .EXPECTED (TT_AND),
    .HOLD     (HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .gif (gif)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Safety net in case something stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic gateVal(input int mode, input int v);
    case (mode)
      M_STUCK0: return 1'b0;
      M_NAND:   return (v != 3);
      default:  return (v == 3);
    endcase
  endfunction

  // Settling mode shows the wrong value until the final hold cycle
  function automatic logic yDrive(input int mode, input int v, input int p);
    if (mode == M_SETTLE && p < HOLD - 1) return !gateVal(M_AND, v);
    return gateVal(mode, v);
  endfunction

  function automatic result_t predict(input int mode);
    result_t    r;
    logic [3:0] tt;
    tt = TT_AND;
    r  = '0;
    for (int v = 0; v < 4; v++) begin
      if (gateVal(mode, v) != tt[v]) begin
        r.mask[v] = 1'b1;
        r.err     = r.err + 3'd1;
      end
    end
    r.pass = (r.mask == 4'd0);
    return r;
  endfunction

  task automatic applyStimulus(input logic s);
    gif.start = s;
  endtask

  // Entered on the negedge after the start edge; leaves on the negedge of the done cycle
  task automatic runBody(input int mode);
    result_t    exp;
    logic [1:0] vb;
    for (int c = 0; c < 4 * HOLD; c++) begin
      vb = 2'(c / HOLD);
      checkCount++;
      if (gif.busy !== 1'b1) $display("[TB] FAIL busy_run c=%0d got %b want 1", c, gif.busy);
      else passCount++;
      checkCount++;
      if ({gif.a, gif.b} !== vb) $display("[TB] FAIL ab_vec c=%0d got %b want %b", c, {gif.a, gif.b}, vb);
      else passCount++;
      checkCount++;
      if (gif.done !== 1'b0) $display("[TB] FAIL done_early c=%0d got %b want 0", c, gif.done);
      else passCount++;
      gif.y = yDrive(mode, c / HOLD, c % HOLD);
      @(posedge clk);
      @(negedge clk);
    end
    checkCount++;
    if (gif.done !== 1'b1) $display("[TB] FAIL done_pulse got %b want 1", gif.done);
    else passCount++;
    checkCount++;
    if (gif.busy !== 1'b0 || {gif.a, gif.b} !== 2'b00)
      $display("[TB] FAIL idle_after busy=%b ab=%b want 0/00", gif.busy, {gif.a, gif.b});
    else passCount++;
    checkCount++;
    if (sbQueue.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty got done with no expected result queued");
    end else begin
      exp = sbQueue.pop_front();
      if ({gif.pass, gif.err_count, gif.fail_mask} !== exp)
        $display("[TB] FAIL result mode=%0d got pass=%b err=%0d mask=%b want pass=%b err=%0d mask=%b",
                 mode, gif.pass, gif.err_count, gif.fail_mask, exp.pass, exp.err, exp.mask);
      else passCount++;
    end
  endtask

  task automatic startRun(input int mode);
    applyStimulus(1'b1);
    sbQueue.push_back(predict(mode));
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0);
    runBody(mode);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b0);
    gif.y = 1'b0;
    repeat (3) @(negedge clk);
    checkCount++;
    if ({gif.a, gif.b, gif.busy, gif.done, gif.pass, gif.err_count, gif.fail_mask} !== 11'd0)
      $display("[TB] FAIL reset_values got a=%b b=%b busy=%b done=%b pass=%b err=%0d mask=%b want all 0",
               gif.a, gif.b, gif.busy, gif.done, gif.pass, gif.err_count, gif.fail_mask);
    else passCount++;
    // Reset and start together: reset wins
    applyStimulus(1'b1);
    @(posedge clk);
    @(negedge clk);
    checkCount++;
    if (gif.busy !== 1'b0) $display("[TB] FAIL reset_beats_start got busy=%b want 0", gif.busy);
    else passCount++;
    applyStimulus(1'b0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_correct_gate();
    startRun(M_AND);
    @(negedge clk);
    checkCount++;
    if (gif.done !== 1'b0 || gif.pass !== 1'b1)
      $display("[TB] FAIL result_hold got done=%b pass=%b want 0/1", gif.done, gif.pass);
    else passCount++;
  endtask

  task automatic test_stuck0();
    startRun(M_STUCK0);
    @(negedge clk);
  endtask

  task automatic test_wrong_gate();
    startRun(M_NAND);
    @(negedge clk);
  endtask

  task automatic test_settling();
    startRun(M_SETTLE);
    @(negedge clk);
  endtask

  task automatic test_start_held();
    int extraRuns;
    extraRuns = 0;
    applyStimulus(1'b1);
    sbQueue.push_back(predict(M_AND));
    @(posedge clk);
    @(negedge clk);
    runBody(M_AND);
    applyStimulus(1'b0);
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (gif.busy === 1'b1) extraRuns++;
    end
    checkCount++;
    if (extraRuns != 0) $display("[TB] FAIL single_run got %0d busy cycles want 0", extraRuns);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    startRun(M_NAND);
    applyStimulus(1'b1);
    sbQueue.push_back(predict(M_AND));
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0);
    checkCount++;
    if (gif.busy !== 1'b1 || gif.done !== 1'b0 || gif.pass !== 1'b0 ||
        gif.err_count !== 3'd0 || gif.fail_mask !== 4'd0)
      $display("[TB] FAIL b2b_clear got busy=%b done=%b pass=%b err=%0d mask=%b want 1/0/0/0/0000",
               gif.busy, gif.done, gif.pass, gif.err_count, gif.fail_mask);
    else passCount++;
    runBody(M_AND);
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int sawDone;
    sawDone = 0;
    applyStimulus(1'b1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0);
    for (int c = 0; c < 2 * HOLD + 1; c++) begin
      gif.y = yDrive(M_AND, c / HOLD, c % HOLD);
      @(posedge clk);
      @(negedge clk);
    end
    checkCount++;
    if ({gif.a, gif.b} !== 2'b10) $display("[TB] FAIL midrun_vec got %b want 10", {gif.a, gif.b});
    else passCount++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkCount++;
    if ({gif.a, gif.b, gif.busy, gif.done, gif.pass, gif.err_count, gif.fail_mask} !== 11'd0)
      $display("[TB] FAIL midrun_reset got a=%b b=%b busy=%b done=%b pass=%b err=%0d mask=%b want all 0",
               gif.a, gif.b, gif.busy, gif.done, gif.pass, gif.err_count, gif.fail_mask);
    else passCount++;
    rst = 1'b0;
    repeat (4 * HOLD + 2) begin
      @(posedge clk);
      @(negedge clk);
      if (gif.done === 1'b1 || gif.busy === 1'b1) sawDone++;
    end
    checkCount++;
    if (sawDone != 0) $display("[TB] FAIL no_done_after_abort got %0d active cycles want 0", sawDone);
    else passCount++;
    startRun(M_AND);
    @(negedge clk);
  endtask

  // Test sequence
  initial begin
    rst = 1'b1;
    gif.start = 1'b0;
    gif.y = 1'b0;
    test_reset();
    test_correct_gate();
    test_stuck0();
    test_wrong_gate();
    test_settling();
    test_start_held();
    test_back_to_back();
    test_reset_midrun();
    checkCount++;
    if (sbQueue.size() != 0) $display("[TB] FAIL scoreboard_leftover got %0d want 0", sbQueue.size());
    else passCount++;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/gate_checker.md
# gate_checker

Synthesizable truth-table checker for 2-input combinational gates: the stimulus-and-response end of the gate test interface (`A`, `B` in, `Y` out). On a start request it walks `{a,b}` through 00, 01, 10, 11 and holds each vector for a fixed number of cycles. It samples `y` on the last hold cycle, compares it against a parameterized expected truth table, and reports pass/fail, an error count and a per-vector fail mask. It sits beside a gate instance in on-chip self-test or FPGA bring-up, replacing a simulation-only stimulus bench.

## Interface
- `EXPECTED`, default `4'b1000`: expected `y` per vector; bit index = `{a,b}` (default is AND).
- `HOLD`, default `4`: cycles each vector is held; legal range 2..255.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request a run; sampled only when `busy`=0.
- `y`  in  1  gate output under test.
- `a`  out  1  gate input A (MSB of vector index).
- `b`  out  1  gate input B (LSB of vector index).
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse when results are valid.
- `pass`  out  1  1 when `fail_mask`==0 after the last run.
- `err_count`  out  3  number of failing vectors, 0..4.
- `fail_mask`  out  4  bit v set if vector v failed.

## Operation
- FSM states:
  - IDLE: `busy`=0. `start`=1 → RUN; clears `err_count`, `fail_mask` and `pass`; `vec`=0; `hold_cnt`=0.
  - RUN: `busy`=1; `{a,b}`=`vec`; `hold_cnt` increments every cycle.
    - When `hold_cnt`==HOLD-1: compare `y` with `EXPECTED[vec]`. On mismatch, set `fail_mask[vec]` and increment `err_count`. Then `hold_cnt`←0.
    - If `vec`==3, go to IDLE, assert `done` and load `pass`. Otherwise `vec`←`vec`+1.
- Mismatch rule: any `y` not equal to the expected bit counts as a failure. In simulation, X/Z on `y` counts as a mismatch (case-inequality semantics).
- `a`/`b` return to 0 when the FSM returns to IDLE.
- `start` while `busy`=1 is ignored, with no queuing.
- `start` in the same cycle `done` is high is accepted, because the FSM is already in IDLE. That cycle's results remain visible while `done`=1, then clear on the next edge.
- Results (`pass`, `err_count`, `fail_mask`) hold their value until the next accepted `start` or `rst`.
- Widths: `vec` 2 bits; `hold_cnt` 8 bits; `err_count` saturates naturally at 4 (never exceeds).

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_mask`=0; FSM in IDLE.
- Let edge E0 be the edge that samples `start`=1.
  - From E0 onward: `busy`=1 and `{a,b}`=00.
  - Vector v is driven for the HOLD cycles following edges E0+v·HOLD … E0+v·HOLD+HOLD-1.
  - `y` for vector v is sampled at edge E0+(v+1)·HOLD.
- At edge E0+4·HOLD: `busy`→0, `done`→1 for exactly one cycle, and `pass`, `err_count`, `fail_mask` are final. Start-to-done latency is 4·HOLD cycles.
- `y` is ignored on the first HOLD-1 cycles of each vector (settling window). Only the last-cycle value counts.
- `rst` mid-run: at the next edge all outputs take reset values and the run is aborted. No `done` pulse is produced.
- `rst` and `start` in the same cycle: reset wins.

## Structure
- Package `gate_check_pkg`:
  - state enum `{IDLE, RUN}`.
  - truth-table constants `TT_AND`=4'b1000, `TT_OR`=4'b1110, `TT_XOR`=4'b0110, `TT_NAND`=4'b0111, `TT_NOR`=4'b0001, `TT_XNOR`=4'b1001.
- One sub-module: `hold_timer`.
  - Ports: clear/enable in, `last` flag out.
  - Parameterized by HOLD; provides `hold_cnt` and the `last` flag.
- The FSM, vector index and result registers live in `gate_checker`.

## Test plan
- Correct gate: AND instance, `EXPECTED`=`TT_AND`, HOLD=4, pulse `start` → `a`/`b` step 00,01,10,11 every 4 cycles; `done` at edge E0+16; `pass`=1, `err_count`=0, `fail_mask`=0000.
- Stuck-at-0 output: `y` tied 0, `EXPECTED`=`TT_AND` → `err_count`=1, `fail_mask`=1000, `pass`=0.
- Wrong gate type: NAND instance, `EXPECTED`=`TT_AND` → `err_count`=4, `fail_mask`=1111, `pass`=0.
- Settling window: `y` forced to the wrong value for the first HOLD-1 cycles of each vector, correct on the last → `pass`=1, `err_count`=0.
- Start handling:
  - `start` held high through a run → exactly one run.
  - `start` high in the `done` cycle → second run begins at that edge, with results cleared on the following edge.
- Reset mid-run: assert `rst` while `vec`=2 → next cycle all outputs 0, no `done`; a subsequent `start` runs normally to `pass`=1.
